muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file.
- Consumes the two register read ports (rs1 and rs2 data) and the destination index.
- Produces a write-back triple (enable, address, data) that drives the register file write port (WE3 / A3 / WD3).
- Executes one operation at a time over multiple cycles, using a start/busy/done handshake towards the pipeline controller.

Parameters:
- Data_Width, 32, operand and result width. Must be even and at least 8.
- Address_Width, 5, width of the destination register index.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous reset, active-high.
- i_start  input  1  request a new operation; sampled only in IDLE.
- i_funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1  input  Data_Width  operand A (register file RD1).
- i_rs2  input  Data_Width  operand B (register file RD2).
- i_rd  input  Address_Width  destination register index.
- i_kill  input  1  abort the in-flight operation (pipeline flush).
- o_busy  output  1  high while the state is not IDLE.
- o_done  output  1  one-cycle pulse; result valid.
- o_we  output  1  write enable to the register file; equals o_done AND (o_rd != 0).
- o_rd  output  Address_Width  destination index, latched at start.
- o_result  output  Data_Width  result, held until the next accepted start.

Behaviour:
- Reset:
  - The state is IDLE while rst is high, effective immediately (asynchronous).
  - All outputs, counters, operand registers and o_result are 0.
  - A reset during an operation discards it; there is no o_done.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If i_start=1 at a posedge, latch i_funct3, i_rs1, i_rs2 and i_rd, and go to CALC with counter=0.
  - i_start while not in IDLE is ignored; there is no queueing.
- CALC:
  - Performs one iteration per cycle for exactly Data_Width cycles (counter 0..Data_Width-1), then goes to DONE.
  - Multiply is shift-add on operand magnitudes into a 2*Data_Width product.
    - Signedness: MUL/MULH use signed A and signed B; MULHSU uses signed A and unsigned B; MULHU uses unsigned A and B.
    - The product is negated at the end if the operand signs differ.
    - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Divide is restoring division on magnitudes.
    - DIV: quotient sign = sign(A) XOR sign(B).
    - REM: remainder sign = sign(A).
- DONE:
  - Lasts one cycle. o_done=1, o_result is registered, o_we as defined in Ports.
  - Next state is IDLE.
- Latency:
  - A start accepted at edge E0 gives o_done high in the cycle after edge E0+Data_Width+1 (33 edges at default width).
  - The earliest next accept is the edge after DONE.
- Special cases (RISC-V defined, no trap):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (A = most negative value, B = -1): DIV gives A; REM gives 0.
- i_kill:
  - In CALC or DONE, i_kill=1 forces IDLE at the next edge.
  - If i_kill=1 in the DONE cycle, o_done and o_we are suppressed combinationally in that cycle.
  - o_result keeps its previous value.
  - If i_start and i_kill are both high in IDLE, i_kill wins and the start is not accepted.
- Operands are latched at start, so later changes on i_rs1/i_rs2 have no effect on the in-flight operation.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Divide by zero, signed overflow, and multiply with either operand 0 go straight from IDLE to DONE.
  - o_done is high in the cycle after edge E0+1.
  - Results are identical to the full path.
- Not defined: every operation takes the full Data_Width+1 latency, and special-case results are produced in DONE.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> o_done after 33 edges, o_result=0xFFFFFFEB, o_we=1, o_rd=5, o_busy low on the next cycle.
- MULHU and MULH:
  - MULHU with rs1=rs2=0xFFFFFFFF -> o_result=0xFFFFFFFE.
  - MULH with the same operands -> 0x00000000.
  - MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- Signed divide:
  - DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD.
  - REM with the same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide special cases:
  - DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF; REMU -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Repeat with MULDIV_EARLY_OUT_EN defined -> o_done 2 edges after start.
- Abort and ignored starts:
  - Assert i_kill at CALC counter=10 -> no o_done or o_we pulse, o_busy=0 next cycle, o_result unchanged.
  - i_start pulsed while busy -> ignored.
- Write-back gating and reset:
  - MUL with rd=0 -> o_done=1, o_we=0.
  - Assert rst mid-CALC -> all outputs 0 immediately.
  - After release, a new start completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register file write port.
// Optional MULDIV_EARLY_OUT_EN: trivial divides and zero-operand multiplies skip the iteration phase.
module muldiv_unit #(
  parameter int Data_Width    = 32,
  parameter int Address_Width = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [2:0]               i_funct3,
  input  logic [Data_Width-1:0]    i_rs1,
  input  logic [Data_Width-1:0]    i_rs2,
  input  logic [Address_Width-1:0] i_rd,
  input  logic                     i_kill,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_we,
  output logic [Address_Width-1:0] o_rd,
  output logic [Data_Width-1:0]    o_result
);

  localparam int CW = $clog2(Data_Width);
  localparam logic [CW-1:0] LastCount = CW'(Data_Width - 1);
  localparam logic [Data_Width-1:0] MostNeg = {1'b1, {(Data_Width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                     state, state_next;
  logic [2:0]                 f3_q;
  logic [Data_Width-1:0]      a_q, b_q;
  logic [Address_Width-1:0]   rd_q;
  logic [CW-1:0]              cnt;
  logic                       prep;
  logic [2*Data_Width-1:0]    acc, acc_next;
  logic [Data_Width-1:0]      result_q;

  // Operand decode from the latched request
  logic                  is_div, sign_a, sign_b, a_neg, b_neg, res_neg;
  logic [Data_Width-1:0] a_mag, b_mag;
  logic                  div_zero, ovf, special_full, early;
  logic [Data_Width-1:0] special_val;

  assign is_div  = f3_q[2];
  assign sign_a  = is_div ? !f3_q[0] : (f3_q != 3'd3);
  assign sign_b  = is_div ? !f3_q[0] : !f3_q[1];
  assign a_neg   = sign_a & a_q[Data_Width-1];
  assign b_neg   = sign_b & b_q[Data_Width-1];
  assign res_neg = a_neg ^ b_neg;
  assign a_mag   = a_neg ? -a_q : a_q;
  assign b_mag   = b_neg ? -b_q : b_q;

  assign div_zero     = is_div && (b_q == '0);
  assign ovf          = is_div && !f3_q[0] && (a_q == MostNeg) && (b_q == '1);
  assign special_full = div_zero | ovf;

`ifdef MULDIV_EARLY_OUT_EN
  logic mul_zero;
  assign mul_zero = !is_div && ((a_q == '0) || (b_q == '0));
  assign early    = special_full | mul_zero;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    special_val = '0;
    if (div_zero)  special_val = f3_q[1] ? a_q : '1;
    else if (ovf)  special_val = f3_q[1] ? '0 : a_q;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  logic [Data_Width:0] sum, shifted, diff;
  logic                ge;

  always_comb begin
    sum     = {1'b0, acc[2*Data_Width-1:Data_Width]} + (acc[0] ? {1'b0, b_mag} : '0);
    shifted = {acc[2*Data_Width-1:Data_Width], acc[Data_Width-1]};
    diff    = shifted - {1'b0, b_mag};
    ge      = shifted >= {1'b0, b_mag};
    if (is_div)
      acc_next = {(ge ? diff[Data_Width-1:0] : shifted[Data_Width-1:0]),
                  acc[Data_Width-2:0], ge};
    else
      acc_next = {sum, acc[Data_Width-1:1]};
  end

  // Sign fix-up and half selection applied to the final iteration's value
  logic [2*Data_Width-1:0] prod;
  logic [Data_Width-1:0]   quo, rem, normal, final_result;

  always_comb begin
    prod = res_neg ? -acc_next : acc_next;
    quo  = acc_next[Data_Width-1:0];
    rem  = acc_next[2*Data_Width-1:Data_Width];
    case (f3_q)
      3'd0:       normal = prod[Data_Width-1:0];
      3'd1, 3'd2,
      3'd3:       normal = prod[2*Data_Width-1:Data_Width];
      3'd4, 3'd5: normal = res_neg ? -quo : quo;
      default:    normal = a_neg ? -rem : rem;
    endcase
    final_result = special_full ? special_val : normal;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_start && !i_kill) state_next = CALC;
      CALC: begin
        if (i_kill)                   state_next = IDLE;
        else if (prep)                state_next = early ? DONE : CALC;
        else if (cnt == LastCount)    state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first CALC cycle (prep) forms operand magnitudes; the next Data_Width cycles iterate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      prep     <= 1'b0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      state <= state_next;
      case (state)
        IDLE: begin
          if (i_start && !i_kill) begin
            f3_q <= i_funct3;
            a_q  <= i_rs1;
            b_q  <= i_rs2;
            rd_q <= i_rd;
            cnt  <= '0;
            prep <= 1'b1;
          end
        end
        CALC: begin
          if (!i_kill) begin
            if (prep) begin
              prep <= 1'b0;
              acc  <= {{Data_Width{1'b0}}, a_mag};
              if (early) result_q <= special_val;
            end else begin
              acc <= acc_next;
              cnt <= cnt + CW'(1);
              if (cnt == LastCount) result_q <= final_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (state != IDLE);
  assign o_done   = (state == DONE) && !i_kill;
  assign o_we     = o_done && (rd_q != '0);
  assign o_rd     = rd_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of model results, latency, kill, reset and write-back gating.
module tb_muldiv_unit;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 100;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [2:0]    i_funct3 = '0;
  logic [W-1:0]  i_rs1 = '0, i_rs2 = '0;
  logic [AW-1:0] i_rd = '0;
  logic          i_kill = 1'b0;
  logic          o_busy, o_done, o_we;
  logic [AW-1:0] o_rd;
  logic [W-1:0]  o_result;

  muldiv_unit #(.Data_Width(W), .Address_Width(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_funct3(i_funct3),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_kill(i_kill),
    .o_busy(o_busy), .o_done(o_done), .o_we(o_we), .o_rd(o_rd), .o_result(o_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [AW-1:0] rd;
    logic          we;
    int            lat;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_res = '0;

  function automatic logic [W-1:0] ref_result(input logic [2:0] f3, input logic [W-1:0] a, b);
    logic signed [63:0] sa, sbv, ps;
    logic [63:0]        pu;
    logic signed [W-1:0] x, y;
    logic [W-1:0]       r;
    bit                 ovf;
    sa  = {{32{a[W-1]}}, a};
    sbv = {{32{b[W-1]}}, b};
    pu  = {32'b0, a} * {32'b0, b};
    x   = a;
    y   = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: r = pu[31:0];
      3'd1: begin ps = sa * sbv; r = ps[63:32]; end
      3'd2: begin ps = sa * $signed({32'b0, b}); r = ps[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : W'(x / y);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : W'(x % y);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [W-1:0] a, b);
    bit special;
    if (f3[2]) special = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else       special = (a == 0) || (b == 0);
    return (EARLY && special) ? 1 : W + 1;
  endfunction

  // Drives one start pulse and records the expected completion
  task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, b, input logic [AW-1:0] rd);
    exp_t e;
    @(negedge clk);
    i_start = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
    e.res = ref_result(f3, a, b);
    e.rd  = rd;
    e.we  = (rd != 0);
    e.lat = ref_latency(f3, a, b);
    exp_q.push_back(e);
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Waits (bounded) for o_done; lat counts posedges after the accepting edge
  task automatic wait_result(input int n0, output bit seen, output int lat);
    int n;
    n = n0; seen = 1'b0; lat = 0;
    while (n < LIMIT) begin
      @(negedge clk);
      if (o_done === 1'b1) begin seen = 1'b1; lat = n; return; end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({o_busy, o_done, o_we, o_rd, o_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b rd=%0d res=%h exp all zero",
               o_busy, o_done, o_we, o_rd, o_result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]    f3s[6];
    logic [W-1:0]  as[6], bs[6];
    logic [AW-1:0] rds[6];
    exp_t e; bit seen; int lat;
    f3s = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd1};
    as  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12345, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd678, 32'h8000_0000};
    rds = '{5'd5, 5'd1, 5'd2, 5'd31, 5'd0, 5'd9};
    for (int i = 0; i < 6; i++) begin
      issue(f3s[i], as[i], bs[i], rds[i]);
      wait_result(0, seen, lat);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL mul[%0d]_timeout no o_done within %0d edges", i, LIMIT);
      end else begin
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL mul[%0d]_latency got %0d exp %0d", i, lat, e.lat); end
        checks++;
        if (o_result !== e.res) begin errors++; $display("FAIL mul[%0d]_result got %h exp %h", i, o_result, e.res); end
        checks++;
        if ({o_we, o_rd} !== {e.we, e.rd}) begin
          errors++; $display("FAIL mul[%0d]_wb got we=%b rd=%0d exp we=%b rd=%0d", i, o_we, o_rd, e.we, e.rd);
        end
        last_res = e.res;
        @(negedge clk);
        checks++;
        if ({o_busy, o_done} !== 2'b00) begin
          errors++; $display("FAIL mul[%0d]_idle_after got busy=%b done=%b exp 0 0", i, o_busy, o_done);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]    f3s[12];
    logic [W-1:0]  as[12], bs[12];
    exp_t e; bit seen; int lat;
    f3s = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd4};
    as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234,
            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 32'd1000};
    bs  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd55, 32'hFFFF_FFF9};
    for (int i = 0; i < 12; i++) begin
      issue(f3s[i], as[i], bs[i], 5'(i + 1));
      wait_result(0, seen, lat);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL div[%0d]_timeout no o_done within %0d edges", i, LIMIT);
      end else begin
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL div[%0d]_latency got %0d exp %0d", i, lat, e.lat); end
        checks++;
        if (o_result !== e.res) begin errors++; $display("FAIL div[%0d]_result got %h exp %h", i, o_result, e.res); end
        checks++;
        if ({o_we, o_rd} !== {e.we, e.rd}) begin
          errors++; $display("FAIL div[%0d]_wb got we=%b rd=%0d exp we=%b rd=%0d", i, o_we, o_rd, e.we, e.rd);
        end
        last_res = e.res;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL div[%0d]_idle_after got busy=%b exp 0", i, o_busy); end
      end
    end
  endtask

  task automatic test_kill();
    exp_t e; bit pulse;
    // Kill mid-iteration: nothing written back, result untouched
    issue(3'd0, 32'd9, 32'd11, 5'd4);
    void'(exp_q.pop_back());
    pulse = 1'b0;
    repeat (11) begin @(negedge clk); pulse |= o_done | o_we; end
    i_kill = 1'b1;
    @(posedge clk);
    #1 i_kill = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL kill_calc_busy got %b exp 0", o_busy); end
    repeat (40) begin @(negedge clk); pulse |= o_done | o_we; end
    checks++;
    if (pulse !== 1'b0) begin errors++; $display("FAIL kill_calc_pulse got done/we pulse %b exp 0", pulse); end
    checks++;
    if (o_result !== last_res) begin errors++; $display("FAIL kill_calc_result got %h exp %h", o_result, last_res); end
    // Kill in the DONE cycle suppresses the pulse combinationally
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd6);
    e = exp_q.pop_back();
    repeat (W + 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_done, o_we, o_result} !== {1'b1, 1'b1, e.res}) begin
      errors++; $display("FAIL kill_done_pre got done=%b we=%b res=%h exp 1 1 %h", o_done, o_we, o_result, e.res);
    end
    last_res = e.res;
    i_kill = 1'b1;
    #1;
    checks++;
    if ({o_done, o_we} !== 2'b00) begin errors++; $display("FAIL kill_done_suppress got done=%b we=%b exp 0 0", o_done, o_we); end
    @(posedge clk);
    #1 i_kill = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL kill_done_busy got %b exp 0", o_busy); end
    // Start and kill together in IDLE: kill wins
    i_start = 1'b1; i_kill = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd3;
    @(posedge clk);
    #1 begin i_start = 1'b0; i_kill = 1'b0; end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL kill_start_idle got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_ignored_start();
    exp_t e; bit seen, pulse; int lat;
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    repeat (5) @(negedge clk);
    i_start = 1'b1; i_funct3 = 3'd0; i_rs1 = $urandom; i_rs2 = $urandom; i_rd = 5'd8;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_result(5, seen, lat);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ignored_timeout no o_done within %0d edges", LIMIT);
    end else begin
      checks++;
      if ({lat, o_result, o_rd} !== {e.lat, e.res, e.rd}) begin
        errors++; $display("FAIL ignored_result got lat=%0d res=%h rd=%0d exp lat=%0d res=%h rd=%0d",
                           lat, o_result, o_rd, e.lat, e.res, e.rd);
      end
      last_res = e.res;
    end
    pulse = 1'b0;
    repeat (40) begin @(negedge clk); pulse |= o_done | o_busy; end
    checks++;
    if (pulse !== 1'b0) begin errors++; $display("FAIL ignored_queued got busy/done activity %b exp 0", pulse); end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit seen, pulse; int lat;
    issue(3'd1, 32'h1357_9BDF, 32'h2468_ACE0, 5'd12);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_we, o_rd, o_result} !== '0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b we=%b rd=%0d res=%h exp all zero",
                         o_busy, o_done, o_we, o_rd, o_result);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    pulse = 1'b0;
    repeat (40) begin @(negedge clk); pulse |= o_done | o_we | o_busy; end
    checks++;
    if (pulse !== 1'b0) begin errors++; $display("FAIL reset_mid_discard got activity %b exp 0", pulse); end
    issue(3'd6, 32'd77, 32'd10, 5'd17);
    wait_result(0, seen, lat);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_recover_timeout no o_done within %0d edges", LIMIT);
    end else begin
      checks++;
      if ({lat, o_result, o_we, o_rd} !== {e.lat, e.res, e.we, e.rd}) begin
        errors++; $display("FAIL reset_recover got lat=%0d res=%h we=%b rd=%0d exp lat=%0d res=%h we=%b rd=%0d",
                           lat, o_result, o_we, o_rd, e.lat, e.res, e.we, e.rd);
      end
      last_res = e.res;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit seen; int lat;
    logic [2:0] f3; logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? W'($urandom_range(1, 300)) : $urandom;
      if (i % 2 == 1) a = -a;
      issue(f3, a, b, 5'($urandom_range(0, 31)));
      wait_result(0, seen, lat);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL b2b[%0d]_timeout no o_done within %0d edges", i, LIMIT);
      end else begin
        checks++;
        if ({lat, o_result, o_we, o_rd, o_busy} !== {e.lat, e.res, e.we, e.rd, 1'b1}) begin
          errors++; $display("FAIL b2b[%0d] f3=%0d a=%h b=%h got lat=%0d res=%h we=%b rd=%0d busy=%b exp lat=%0d res=%h we=%b rd=%0d busy=1",
                             i, f3, a, b, lat, o_result, o_we, o_rd, o_busy, e.lat, e.res, e.we, e.rd);
        end
        last_res = e.res;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_kill();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
